// File: rtl/rot_shift_seq.sv
// rot_shift_seq: multicycle 32-bit SLL/SRA/ROL/ROR unit.
// One shift stage per clock (16, 8, 4, 2, 1); fixed 5-cycle latency.
module rot_shift_seq (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] data_operandA,
  input  logic [4:0]  ctrl_shiftamt,
  input  logic [1:0]  ctrl_op,
  output logic        busy,
  output logic        result_ready,
  output logic [31:0] data_result
);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  amt_q, amt_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  step_q, step_d;
  logic        rdy_q, rdy_d;
  logic [31:0] stage_w;

  // s is always a constant at the call site, so each use folds to wiring
  function automatic logic [31:0] shift_by(
    input logic [31:0] w,
    input logic [1:0]  op,
    input int unsigned s
  );
    logic [31:0] r;
    unique case (op)
      2'b00:   r = w << s;
      2'b01:   r = 32'($signed(w) >>> s);
      2'b10:   r = (w << s) | (w >> (32 - s));
      default: r = (w >> s) | (w << (32 - s));
    endcase
    return r;
  endfunction

  always_comb begin
    stage_w = work_q;
    unique case (1'b1)
      (step_q == 3'd4):
        if (amt_q[4]) stage_w = shift_by(work_q, op_q, 16);
      (step_q == 3'd3):
        if (amt_q[3]) stage_w = shift_by(work_q, op_q, 8);
      (step_q == 3'd2):
        if (amt_q[2]) stage_w = shift_by(work_q, op_q, 4);
      (step_q == 3'd1):
        if (amt_q[1]) stage_w = shift_by(work_q, op_q, 2);
      (step_q == 3'd0):
        if (amt_q[0]) stage_w = shift_by(work_q, op_q, 1);
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    res_d   = res_q;
    amt_d   = amt_q;
    op_d    = op_q;
    step_d  = step_q;
    rdy_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = data_operandA;
          amt_d   = ctrl_shiftamt;
          op_d    = ctrl_op;
          step_d  = 3'd4;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d = stage_w;
        if (step_q == 3'd0) begin
          res_d   = stage_w;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end else begin
          step_d = step_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      res_q   <= '0;
      amt_q   <= '0;
      op_q    <= '0;
      step_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      res_q   <= res_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
      step_q  <= step_d;
      rdy_q   <= rdy_d;
    end
  end

  assign busy         = (state_q == RUN);
  assign result_ready = rdy_q;
  assign data_result  = res_q;

endmodule
